// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: LC-3 instruction fetch unit.
//   Owns the PC and issues one fixed-latency instruction read per fetch. The fetched word is held
//   for decode over a valid/ready handshake. Control-flow redirects (BR, JMP/RET, JSR/JSRR) from
//   execute move the PC and abort any fetch in flight.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   fetch_start               request one fetch at pc (honoured in IDLE only)
//   redirect_valid            execute presents a control-flow instruction
//   opCode_in, offset_in,     opcode, PCoffset, JSR/JSRR select, base register,
//   jsr_imm_in, reg_in,       BR condition mask and current condition codes
//   br_nzp, result_nzp
//   mem_rdata                 read data, valid MEM_LAT cycles after rd_en_out
//   addr_out, rd_en_out,      read address/strobe, write enable (always 0)
//   wea_out
//   instr_out, instr_valid,   fetched word to decode with its handshake
//   instr_ready
//   pc                        address of the next instruction to fetch
//   link_pc, link_we          R7 return address and one-cycle write strobe
module fetch_pc_unit #(
   parameter int unsigned       ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] PC_RESET   = '0,
   parameter int unsigned       MEM_LAT    = 1,
   parameter bit                AUTO_FETCH = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_start,
   input  logic              redirect_valid,
   input  logic [3:0]        opCode_in,
   input  logic [10:0]       offset_in,
   input  logic              jsr_imm_in,
   input  logic [ADDR_W-1:0] reg_in,
   input  logic [2:0]        br_nzp,
   input  logic [2:0]        result_nzp,
   input  logic [15:0]       mem_rdata,
   output logic [ADDR_W-1:0] addr_out,
   output logic              rd_en_out,
   output logic              wea_out,
   output logic [15:0]       instr_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link_pc,
   output logic              link_we
);

   localparam logic [3:0] OpBr  = 4'b0000;
   localparam logic [3:0] OpJmp = 4'b1100;
   localparam logic [3:0] OpJsr = 4'b0100;
   localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] last_npc_q;
   logic [3:0]        lat_cnt_q;
   logic [15:0]       instr_q;
   logic              instr_valid_q;
   logic [ADDR_W-1:0] link_pc_q;
   logic              link_we_q;

   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] jsr_target;
   logic [ADDR_W-1:0] target;
   logic              taken;
   logic              is_jsr;
   logic              handshake;

   // Relative targets are based on last_npc (PC after the last delivered word), not the live pc.
   assign br_target  = last_npc_q + {{(ADDR_W-9){offset_in[8]}}, offset_in[8:0]};
   assign jsr_target = last_npc_q + {{(ADDR_W-11){offset_in[10]}}, offset_in};

   always_comb begin
      taken  = 1'b0;
      is_jsr = 1'b0;
      target = last_npc_q;
      if (redirect_valid) begin
         case (opCode_in)
            OpBr: begin
               if (|(br_nzp & result_nzp)) begin
                  taken  = 1'b1;
                  target = br_target;
               end
            end
            OpJmp: begin
               taken  = 1'b1;
               target = reg_in;
            end
            OpJsr: begin
               taken  = 1'b1;
               is_jsr = 1'b1;
               target = jsr_imm_in ? jsr_target : reg_in;
            end
            default: ;
         endcase
      end
   end

   assign handshake = (state_q == StHold) && instr_valid_q && instr_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         pc_q          <= PC_RESET;
         last_npc_q    <= PC_RESET;
         lat_cnt_q     <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         link_pc_q     <= '0;
         link_we_q     <= 1'b0;
      end else begin
         link_we_q <= is_jsr;
         if (is_jsr) begin
            link_pc_q <= last_npc_q;
         end
         if (handshake) begin
            last_npc_q <= pc_q;
         end

         unique case (state_q)
            StIdle: begin
               if (fetch_start) begin
                  state_q <= StReq;
               end
            end
            StReq: begin
               pc_q      <= pc_q + 1'b1;
               lat_cnt_q <= LatInit;
               state_q   <= StWait;
            end
            StWait: begin
               if (lat_cnt_q == 4'd0) begin
                  instr_q       <= mem_rdata;
                  instr_valid_q <= 1'b1;
                  state_q       <= StHold;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 1'b1;
               end
            end
            StHold: begin
               if (handshake) begin
                  instr_valid_q <= 1'b0;
                  state_q       <= AUTO_FETCH ? StReq : StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         // A taken redirect overrides everything above: the in-flight fetch is dropped.
         if (taken) begin
            pc_q          <= target;
            instr_valid_q <= 1'b0;
            if ((state_q == StIdle) && fetch_start) begin
               state_q <= StReq;
            end else begin
               state_q <= AUTO_FETCH ? StReq : StIdle;
            end
         end
      end
   end

   assign rd_en_out   = (state_q == StReq);
   assign addr_out    = rd_en_out ? pc_q : '0;
   assign wea_out     = 1'b0;
   assign instr_out   = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign link_pc     = link_pc_q;
   assign link_we     = link_we_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_start = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [3:0]  opCode_in = 4'h0;
   logic [10:0] offset_in = '0;
   logic        jsr_imm_in = 1'b0;
   logic [15:0] reg_in = '0;
   logic [2:0]  br_nzp = '0;
   logic [2:0]  result_nzp = '0;
   logic [15:0] mem_rdata = '0;
   logic        instr_ready = 1'b0;
   logic [15:0] addr_out, instr_out, pc, link_pc;
   logic        rd_en_out, wea_out, instr_valid, link_we;

   logic        a_fetch_start = 1'b0;
   logic        a_redirect_valid = 1'b0;
   logic        a_instr_ready = 1'b0;
   logic [15:0] a_addr_out, a_instr_out, a_pc, a_link_pc;
   logic        a_rd_en_out, a_wea_out, a_instr_valid, a_link_we;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.ADDR_W(16), .PC_RESET(16'h0000), .MEM_LAT(2), .AUTO_FETCH(1'b0)) dut (
      .clk(clk), .rst(rst), .fetch_start(fetch_start), .redirect_valid(redirect_valid),
      .opCode_in(opCode_in), .offset_in(offset_in), .jsr_imm_in(jsr_imm_in), .reg_in(reg_in),
      .br_nzp(br_nzp), .result_nzp(result_nzp), .mem_rdata(mem_rdata), .addr_out(addr_out),
      .rd_en_out(rd_en_out), .wea_out(wea_out), .instr_out(instr_out),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .link_pc(link_pc),
      .link_we(link_we)
   );

   fetch_pc_unit #(.ADDR_W(16), .PC_RESET(16'h0000), .MEM_LAT(1), .AUTO_FETCH(1'b1)) dut_a (
      .clk(clk), .rst(rst), .fetch_start(a_fetch_start), .redirect_valid(a_redirect_valid),
      .opCode_in(opCode_in), .offset_in(offset_in), .jsr_imm_in(jsr_imm_in), .reg_in(reg_in),
      .br_nzp(br_nzp), .result_nzp(result_nzp), .mem_rdata(mem_rdata),
      .addr_out(a_addr_out), .rd_en_out(a_rd_en_out), .wea_out(a_wea_out),
      .instr_out(a_instr_out), .instr_valid(a_instr_valid), .instr_ready(a_instr_ready),
      .pc(a_pc), .link_pc(a_link_pc), .link_we(a_link_we)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fetch one word on dut; optionally complete the handshake afterwards.
   task automatic do_fetch(input logic [15:0] data, input bit hs);
      int n = 0;
      mem_rdata   = data;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      while (instr_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         $display("FAIL fetch_timeout: instr_valid=%b after %0d cycles, want 1", instr_valid, n);
         errors++;
      end
      if (hs) begin
         instr_ready = 1'b1;
         tick();
         instr_ready = 1'b0;
      end
   endtask

   task automatic jmp(input logic [15:0] addr);
      redirect_valid = 1'b1;
      opCode_in      = 4'b1100;
      reg_in         = addr;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) tick();
      checks++;
      if (pc !== 16'h0 || addr_out !== 16'h0 || wea_out !== 1'b0 || rd_en_out !== 1'b0 ||
          instr_valid !== 1'b0 || link_we !== 1'b0) begin
         $display("FAIL reset: pc=%h addr=%h wea=%b rd=%b v=%b lwe=%b, want all 0",
                  pc, addr_out, wea_out, rd_en_out, instr_valid, link_we);
         errors++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      mem_rdata   = 16'h1021;
      checks++;
      if (rd_en_out !== 1'b1 || addr_out !== 16'h0000) begin
         $display("FAIL fetch_req: rd=%b addr=%h, want 1 0000", rd_en_out, addr_out);
         errors++;
      end
      tick();
      checks++;
      if (rd_en_out !== 1'b0 || instr_valid !== 1'b0 || addr_out !== 16'h0000) begin
         $display("FAIL fetch_wait1: rd=%b v=%b addr=%h, want 0 0 0000",
                  rd_en_out, instr_valid, addr_out);
         errors++;
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0) begin
         $display("FAIL fetch_wait2: v=%b, want 0", instr_valid);
         errors++;
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 16'h1021 || pc !== 16'h0001) begin
         $display("FAIL fetch_hold: v=%b instr=%h pc=%h, want 1 1021 0001",
                  instr_valid, instr_out, pc);
         errors++;
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || rd_en_out !== 1'b0) begin
         $display("FAIL fetch_handshake: v=%b rd=%b, want 0 0", instr_valid, rd_en_out);
         errors++;
      end
   endtask

   task automatic test_br();
      repeat (4) do_fetch(16'h0000, 1'b1);
      do_fetch(16'h0BAD, 1'b0);
      // last_npc=0005, pc=0006, holding a word
      redirect_valid = 1'b1;
      opCode_in      = 4'b0000;
      br_nzp         = 3'b110;
      offset_in      = 11'h1FC;
      result_nzp     = 3'b001;
      tick();
      checks++;
      if (pc !== 16'h0006 || instr_valid !== 1'b1) begin
         $display("FAIL br_not_taken: pc=%h v=%b, want 0006 1", pc, instr_valid);
         errors++;
      end
      result_nzp = 3'b010;
      tick();
      checks++;
      if (pc !== 16'h0001 || instr_valid !== 1'b0) begin
         $display("FAIL br_taken: pc=%h v=%b, want 0001 0", pc, instr_valid);
         errors++;
      end
      br_nzp     = 3'b000;
      result_nzp = 3'b111;
      offset_in  = 11'h010;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (pc !== 16'h0001) begin
         $display("FAIL br_nzp000: pc=%h, want 0001", pc);
         errors++;
      end
   endtask

   task automatic test_jsr();
      jmp(16'h000F);
      checks++;
      if (pc !== 16'h000F) begin
         $display("FAIL jmp_0f: pc=%h, want 000f", pc);
         errors++;
      end
      do_fetch(16'h0000, 1'b1);
      redirect_valid = 1'b1;
      opCode_in      = 4'b0100;
      jsr_imm_in     = 1'b1;
      offset_in      = 11'h020;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (pc !== 16'h0030 || link_pc !== 16'h0010 || link_we !== 1'b1) begin
         $display("FAIL jsr: pc=%h link=%h we=%b, want 0030 0010 1", pc, link_pc, link_we);
         errors++;
      end
      tick();
      checks++;
      if (link_we !== 1'b0 || pc !== 16'h0030) begin
         $display("FAIL jsr_strobe: we=%b pc=%h, want 0 0030", link_we, pc);
         errors++;
      end
      redirect_valid = 1'b1;
      jsr_imm_in     = 1'b0;
      reg_in         = 16'h1234;
      tick();
      checks++;
      if (pc !== 16'h1234 || link_pc !== 16'h0010 || link_we !== 1'b1) begin
         $display("FAIL jsrr: pc=%h link=%h we=%b, want 1234 0010 1", pc, link_pc, link_we);
         errors++;
      end
      jsr_imm_in = 1'b1;
      offset_in  = 11'h7F8;
      tick();
      checks++;
      if (pc !== 16'h0008) begin
         $display("FAIL jsr_neg: pc=%h, want 0008", pc);
         errors++;
      end
      opCode_in = 4'b1100;
      reg_in    = 16'h4000;
      tick();
      checks++;
      if (pc !== 16'h4000 || link_we !== 1'b0) begin
         $display("FAIL jmp_4000: pc=%h we=%b, want 4000 0", pc, link_we);
         errors++;
      end
      opCode_in = 4'b0001;
      reg_in    = 16'h1111;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (pc !== 16'h4000) begin
         $display("FAIL other_op: pc=%h, want 4000", pc);
         errors++;
      end
   endtask

   task automatic test_backpressure();
      do_fetch(16'hABCD, 1'b0);
      repeat (10) begin
         tick();
         checks++;
         if (instr_out !== 16'hABCD || instr_valid !== 1'b1 || rd_en_out !== 1'b0) begin
            $display("FAIL backpressure: instr=%h v=%b rd=%b, want abcd 1 0",
                     instr_out, instr_valid, rd_en_out);
            errors++;
         end
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || rd_en_out !== 1'b0 || pc !== 16'h4001) begin
         $display("FAIL bp_release: v=%b rd=%b pc=%h, want 0 0 4001", instr_valid, rd_en_out, pc);
         errors++;
      end
   endtask

   task automatic test_wrap_abort();
      bit seen = 1'b0;
      jmp(16'hFFFF);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      checks++;
      if (rd_en_out !== 1'b1 || addr_out !== 16'hFFFF) begin
         $display("FAIL wrap_req: rd=%b addr=%h, want 1 ffff", rd_en_out, addr_out);
         errors++;
      end
      tick();
      checks++;
      if (pc !== 16'h0000) begin
         $display("FAIL wrap_pc: pc=%h, want 0000", pc);
         errors++;
      end
      repeat (2) tick();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      // abort a read while waiting on memory
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      tick();
      jmp(16'h0200);
      checks++;
      if (pc !== 16'h0200) begin
         $display("FAIL abort_pc: pc=%h, want 0200", pc);
         errors++;
      end
      repeat (6) begin
         if (instr_valid !== 1'b0 || rd_en_out !== 1'b0) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen) begin
         $display("FAIL abort_quiet: valid/rd seen after abort=%b, want 0", seen);
         errors++;
      end
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      checks++;
      if (rd_en_out !== 1'b1 || addr_out !== 16'h0200) begin
         $display("FAIL abort_refetch: rd=%b addr=%h, want 1 0200", rd_en_out, addr_out);
         errors++;
      end
   endtask

   task automatic test_simultaneous();
      int n = 0;
      while (instr_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      // fetch_start + redirect in IDLE
      fetch_start    = 1'b1;
      redirect_valid = 1'b1;
      opCode_in      = 4'b1100;
      reg_in         = 16'h0300;
      tick();
      fetch_start    = 1'b0;
      redirect_valid = 1'b0;
      checks++;
      if (rd_en_out !== 1'b1 || addr_out !== 16'h0300) begin
         $display("FAIL start_redirect: rd=%b addr=%h, want 1 0300", rd_en_out, addr_out);
         errors++;
      end
      repeat (3) tick();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      do_fetch(16'h0000, 1'b0);
      // HOLD, pc=0302, last_npc=0301: handshake + JMP together
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      opCode_in      = 4'b1100;
      reg_in         = 16'h0500;
      tick();
      instr_ready    = 1'b0;
      checks++;
      if (pc !== 16'h0500 || instr_valid !== 1'b0) begin
         $display("FAIL hs_redirect: pc=%h v=%b, want 0500 0", pc, instr_valid);
         errors++;
      end
      // BR with offset 0 exposes last_npc, which the handshake advanced to 0302
      opCode_in  = 4'b0000;
      br_nzp     = 3'b111;
      result_nzp = 3'b001;
      offset_in  = 11'h000;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (pc !== 16'h0302) begin
         $display("FAIL hs_last_npc: pc=%h, want 0302", pc);
         errors++;
      end
   endtask

   task automatic test_auto();
      a_fetch_start = 1'b1;
      tick();
      a_fetch_start = 1'b0;
      mem_rdata     = 16'h5555;
      checks++;
      if (a_rd_en_out !== 1'b1 || a_addr_out !== 16'h0000) begin
         $display("FAIL auto_req: rd=%b addr=%h, want 1 0000", a_rd_en_out, a_addr_out);
         errors++;
      end
      tick();
      checks++;
      if (a_instr_valid !== 1'b0) begin
         $display("FAIL auto_wait: v=%b, want 0", a_instr_valid);
         errors++;
      end
      tick();
      checks++;
      if (a_instr_valid !== 1'b1 || a_instr_out !== 16'h5555) begin
         $display("FAIL auto_hold: v=%b instr=%h, want 1 5555", a_instr_valid, a_instr_out);
         errors++;
      end
      a_instr_ready = 1'b1;
      tick();
      a_instr_ready = 1'b0;
      checks++;
      if (a_rd_en_out !== 1'b1 || a_addr_out !== 16'h0001 || a_instr_valid !== 1'b0) begin
         $display("FAIL auto_refetch: rd=%b addr=%h v=%b, want 1 0001 0",
                  a_rd_en_out, a_addr_out, a_instr_valid);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || rd_en_out !== 1'b0 || pc !== 16'h0000) begin
         $display("FAIL reset_wait: v=%b rd=%b pc=%h, want 0 0 0000", instr_valid, rd_en_out, pc);
         errors++;
      end
      tick();
      rst = 1'b0;
      do_fetch(16'h7777, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || instr_out !== 16'h0000 || pc !== 16'h0000) begin
         $display("FAIL reset_hold: v=%b instr=%h pc=%h, want 0 0000 0000",
                  instr_valid, instr_out, pc);
         errors++;
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_br();
      test_jsr();
      test_backpressure();
      test_wrap_abort();
      test_simultaneous();
      test_auto();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
